// File: rtl/taiga_types.sv
// Shared taiga type definitions; fifo_status_t bundles FIFO status for consumers.
package taiga_types;

  typedef struct packed {
    logic valid;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/taiga_fifo_ptr.sv
// Wrapping modulo-DEPTH pointer with increment and synchronous clear.
module taiga_fifo_ptr #(
  parameter int DEPTH = 6,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  // Explicit wrap at DEPTH-1 so non-power-of-2 depths index correctly.
  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_ptr <= '0;
    else if (i_inc)
      r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/taiga_fifo_thresh.sv
// FWFT FIFO with arbitrary depth, almost-full/empty thresholds and sticky
// overflow/underflow flags. Status flags decode from the registered count only.
module taiga_fifo_thresh
  import taiga_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 6,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic                              pop,
  input  logic                              err_clr,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              valid,
  output logic                              full,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PW-1:0]         w_wptr;
  logic [PW-1:0]         w_rptr;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  fifo_status_t          w_status;

  assign w_status.valid        = (r_count != '0);
  assign w_status.full         = (r_count == CW'(FIFO_DEPTH));
  assign w_status.almost_full  = (int'(r_count) >= AF_THRESH);
  assign w_status.almost_empty = (int'(r_count) <= AE_THRESH);
  assign w_status.overflow     = r_overflow;
  assign w_status.underflow    = r_underflow;

  // A pop on a full FIFO frees the slot the same-cycle push writes into.
  assign w_pop_acc  = pop & w_status.valid & ~flush;
  assign w_push_acc = push & ~flush & (~w_status.full | w_pop_acc);
  assign w_ovf_set  = push & w_status.full & ~pop & ~flush;
  assign w_unf_set  = pop & ~w_status.valid & ~flush;

  taiga_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(PW)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_push_acc),
    .o_ptr (w_wptr)
  );

  taiga_fifo_ptr #(.DEPTH(FIFO_DEPTH), .PW(PW)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (flush),
    .i_inc (w_pop_acc),
    .o_ptr (w_rptr)
  );

  always_ff @(posedge clk) begin
    if (w_push_acc)
      r_mem[w_wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      r_count <= '0;
    else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Set wins over a same-cycle err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_unf_set)    r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

  assign data_out     = r_mem[w_rptr];
  assign count        = r_count;
  assign valid        = w_status.valid;
  assign full         = w_status.full;
  assign almost_full  = w_status.almost_full;
  assign almost_empty = w_status.almost_empty;
  assign overflow     = w_status.overflow;
  assign underflow    = w_status.underflow;

endmodule

// File: tb/tb_taiga_fifo_thresh.sv
// Self-checking bench: directed vector table, hand sequences, and randomized
// traffic against a queue-based reference model.
module tb_taiga_fifo_thresh;

  localparam int DEPTH = 6;

  logic        clk = 1'b0;
  logic        rst, flush, push, pop, err_clr;
  logic [31:0] data_in, data_out;
  logic        valid, full, almost_full, almost_empty, overflow, underflow;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  taiga_fifo_thresh dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .data_in(data_in),
    .pop(pop), .err_clr(err_clr), .data_out(data_out), .valid(valid),
    .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, push, pop, clr;
    logic [31:0] din;
    int          cnt;
    logic        v, f, af, ae, ov, un;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic fl, input logic pu, input logic po,
                       input logic cl, input logic [31:0] d);
    rst = r; flush = fl; push = pu; pop = po; err_clr = cl; data_in = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " count"}, 32'(count), 0);
    chk({tag, " valid"}, 32'(valid), 0);
    chk({tag, " full"}, 32'(full), 0);
    chk({tag, " almost_full"}, 32'(almost_full), 0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 1);
    chk({tag, " overflow"}, 32'(overflow), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // reference model state
  logic [31:0] q [$];
  logic        m_ov, m_un;

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk_reset("reset");
    drive(0, 0, 0, 0, 0, 0);

    //            fl pu po cl din         cnt v f af ae ov un dout
    tbl[0]  = '{0, 1, 0, 0, 32'h10, 1, 1, 0, 0, 1, 0, 0, 32'h10};
    tbl[1]  = '{0, 1, 0, 0, 32'h11, 2, 1, 0, 0, 0, 0, 0, 32'h10};
    tbl[2]  = '{0, 1, 0, 0, 32'h12, 3, 1, 0, 0, 0, 0, 0, 32'h10};
    tbl[3]  = '{0, 1, 0, 0, 32'h13, 4, 1, 0, 0, 0, 0, 0, 32'h10};
    tbl[4]  = '{0, 1, 0, 0, 32'h14, 5, 1, 0, 1, 0, 0, 0, 32'h10};
    tbl[5]  = '{0, 1, 0, 0, 32'h15, 6, 1, 1, 1, 0, 0, 0, 32'h10};
    tbl[6]  = '{0, 1, 0, 0, 32'h99, 6, 1, 1, 1, 0, 1, 0, 32'h10};
    tbl[7]  = '{0, 0, 0, 1, 32'h00, 6, 1, 1, 1, 0, 0, 0, 32'h10};
    tbl[8]  = '{0, 1, 1, 0, 32'h16, 6, 1, 1, 1, 0, 0, 0, 32'h11};
    tbl[9]  = '{0, 0, 1, 0, 32'h00, 5, 1, 0, 1, 0, 0, 0, 32'h12};
    tbl[10] = '{1, 1, 1, 0, 32'h77, 0, 0, 0, 0, 1, 0, 0, 32'h0};
    tbl[11] = '{0, 1, 1, 0, 32'hAB, 1, 1, 0, 0, 1, 0, 1, 32'hAB};
    tbl[12] = '{0, 0, 1, 1, 32'h00, 0, 0, 0, 0, 1, 0, 0, 32'h0};
    tbl[13] = '{0, 0, 1, 0, 32'h00, 0, 0, 0, 0, 1, 0, 1, 32'h0};
    tbl[14] = '{0, 0, 1, 1, 32'h00, 0, 0, 0, 0, 1, 0, 1, 32'h0};
    tbl[15] = '{0, 0, 0, 1, 32'h00, 0, 0, 0, 0, 1, 0, 0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      drive(0, tbl[i].flush, tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
      cyc();
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].f));
      chk($sformatf("vec%0d almost_full", i), 32'(almost_full), 32'(tbl[i].af));
      chk($sformatf("vec%0d almost_empty", i), 32'(almost_empty), 32'(tbl[i].ae));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(tbl[i].ov));
      chk($sformatf("vec%0d underflow", i), 32'(underflow), 32'(tbl[i].un));
      if (tbl[i].v) chk($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
    end
    drive(0, 0, 0, 0, 0, 0);

    // flush then push: entry visible one cycle later
    drive(0, 0, 1, 0, 0, 32'h55);
    cyc();
    chk("post-flush push data_out", data_out, 32'h55);
    chk("post-flush push count", 32'(count), 1);

    // steady full streaming across the pointer wrap, then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 1, 0, 0, 32'h100 + 32'(i));
      cyc();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, 1, 0, 32'h106 + 32'(i));
      cyc();
      chk($sformatf("stream%0d count", i), 32'(count), 6);
      chk($sformatf("stream%0d data_out", i), data_out, 32'h101 + 32'(i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d data_out", i), data_out, 32'h114 + 32'(i));
      drive(0, 0, 0, 1, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drain valid", 32'(valid), 0);
    chk("drain underflow", 32'(underflow), 0);

    // reset mid-operation with overflow set and traffic asserted
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(0, 0, 1, 0, 0, 32'h200 + 32'(i));
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      cyc();
    end
    chk("pre-rst count", 32'(count), 3);
    chk("pre-rst overflow", 32'(overflow), 1);
    chk("pre-rst data_out", data_out, 32'h203);
    drive(1, 1, 1, 1, 1, 32'hDEAD);
    cyc();
    chk_reset("mid-rst");
    drive(0, 0, 0, 0, 0, 0);

    // randomized traffic against the queue model
    do_reset();
    q.delete();
    m_ov = 0; m_un = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, fl, pu, po, cl, m_full, m_valid, pacc, uacc;
      logic [31:0] d;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 49) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 19) == 0);
      d  = $urandom;
      drive(r, fl, pu, po, cl, d);

      m_full  = (q.size() == DEPTH);
      m_valid = (q.size() != 0);
      pacc = po && m_valid && !fl;
      uacc = pu && !fl && (!m_full || pacc);
      if (r) begin
        q.delete();
        m_ov = 0; m_un = 0;
      end else begin
        if (pu && m_full && !po && !fl) m_ov = 1;
        else if (cl) m_ov = 0;
        if (po && !m_valid && !fl) m_un = 1;
        else if (cl) m_un = 0;
        if (fl) q.delete();
        else begin
          if (pacc) void'(q.pop_front());
          if (uacc) q.push_back(d);
        end
      end

      cyc();
      chk($sformatf("rnd%0d count", n), 32'(count), 32'(q.size()));
      chk($sformatf("rnd%0d valid", n), 32'(valid), 32'(q.size() != 0));
      chk($sformatf("rnd%0d full", n), 32'(full), 32'(q.size() == DEPTH));
      chk($sformatf("rnd%0d almost_full", n), 32'(almost_full), 32'(q.size() >= 5));
      chk($sformatf("rnd%0d almost_empty", n), 32'(almost_empty), 32'(q.size() <= 1));
      chk($sformatf("rnd%0d overflow", n), 32'(overflow), 32'(m_ov));
      chk($sformatf("rnd%0d underflow", n), 32'(underflow), 32'(m_un));
      if (q.size() != 0) chk($sformatf("rnd%0d data_out", n), data_out, q[0]);
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/taiga_fifo_thresh.md
TAIGA_FIFO_THRESH -- requirements
Module: taiga_fifo_thresh

Interface
REQ-001 Parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter FIFO_DEPTH, default 6, entry count; any integer >=2, not restricted to powers of 2.
REQ-003 Parameter AF_THRESH, default FIFO_DEPTH-1, almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 1, almost_empty asserts when count <= AE_THRESH.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 flush  input  1  discard all entries.
REQ-008 push  input  1  enqueue request.
REQ-009 data_in  input  DATA_WIDTH  enqueue payload.
REQ-010 pop  input  1  dequeue request.
REQ-011 err_clr  input  1  clear sticky error flags.
REQ-012 data_out  output  DATA_WIDTH  head entry, first-word-fall-through.
REQ-013 valid  output  1  count != 0.
REQ-014 full  output  1  count == FIFO_DEPTH.
REQ-015 almost_full / almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-016 count  output  $clog2(FIFO_DEPTH+1)  current occupancy.
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 data_out SHALL equal the oldest entry whenever valid=1, combinationally from storage (zero-latency read); value undefined when valid=0.
REQ-019 Accepted push = push & ~flush & (~full | pop_acc); accepted pop = pop & valid & ~flush.
REQ-020 Push+pop in the same cycle when full SHALL both be accepted; count unchanged.
REQ-021 Push+pop when empty: push accepted, pop rejected, count becomes 1, underflow set.
REQ-022 Write and read pointers SHALL advance by 1 per accepted op and wrap from FIFO_DEPTH-1 to 0 (no power-of-2 rounding).
REQ-023 count SHALL update next cycle: +1 push only, -1 pop only, unchanged both/neither; never exceeds FIFO_DEPTH or goes below 0.
REQ-024 Storage written only on accepted push; rejected push SHALL NOT modify storage, pointers or count.
REQ-025 flush SHALL have priority: next cycle pointers=0, count=0, valid=0; same-cycle push/pop ignored and raise no error.
REQ-026 overflow SHALL set when push & full & ~pop & ~flush; underflow SHALL set when pop & ~valid & ~flush.
REQ-027 Error flags sticky until err_clr; same-cycle set and err_clr -> flag remains set.
REQ-028 valid, full, almost_full, almost_empty SHALL be decoded from registered count (no input-to-flag combinational path).

Reset
REQ-029 On rst: pointers=0, count=0, valid=0, full=0, almost_full=(AF_THRESH==0), almost_empty=1, overflow=0, underflow=0.
REQ-030 rst SHALL override flush, push, pop, err_clr; storage contents not reset.
REQ-031 rst asserted mid-operation SHALL discard all entries in one cycle.

Structure
REQ-032 fifo_status_t packed struct {valid, full, almost_full, almost_empty, overflow, underflow} SHALL be added to taiga_types for status aggregation by consumers.
REQ-033 Pointer width and count width are local constants, not package members.
REQ-034 One sub-module taiga_fifo_ptr (wrapping modulo-FIFO_DEPTH counter with increment and clear) SHALL be instantiated for write and read pointers.
REQ-035 Storage SHALL be a register/LUTRAM array of FIFO_DEPTH entries, single write port, asynchronous read.

Verification (FIFO_DEPTH=6, AF_THRESH=5, AE_THRESH=1, DATA_WIDTH=32)
REQ-036 Push 0x10..0x15 over 6 cycles, then 6 pops -> full=1 and count=6 after 6th push, almost_full=1 at count 5, data_out 0x10..0x15 in order, valid=0 at end.
REQ-037 Fill to 6, push 0x99 without pop -> overflow=1, count stays 6, drained data excludes 0x99; err_clr -> overflow=0 next cycle.
REQ-038 Fill to 6, 20 cycles of simultaneous push/pop with incrementing data -> count stays 6, output order strictly incrementing across pointer wrap at index 5->0.
REQ-039 Empty FIFO, pop with push 0xAB -> underflow=1, count=1, data_out=0xAB.
REQ-040 Count 4, flush with push=1 -> next cycle count=0, valid=0, almost_empty=1, no error flags; subsequent push 0x55 appears on data_out next cycle.
REQ-041 Count 3 and overflow set, assert rst one cycle -> all outputs equal REQ-029 values next cycle.
